// File: rtl/ibex_mem_arbiter_if.sv
// Ibex-style memory request/response bundle (req/gnt/rvalid).
// The master drives the request fields. The slave answers with grant and response.
interface ibex_mem_arbiter_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/ibex_mem_arbiter.sv
// Two-to-one arbiter that shares one Ibex-style memory port between fetch and LSU.
// The request path is combinational and a request stays locked until it is granted.
// In-order responses are steered back to their requester through a FIFO of source tags.
module ibex_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2,    // 1..8
    parameter bit          DataPriority   = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ibex_mem_arbiter_if.slave  instr_if,
    ibex_mem_arbiter_if.slave  data_if,
    ibex_mem_arbiter_if.master mem_if,
    output logic               unexp_rsp_o
);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    typedef enum logic {
        SrcInstr = 1'b0,
        SrcData  = 1'b1
    } src_e;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic            lock_vld_q, lock_vld_d;
    src_e            lock_src_q, lock_src_d;
    src_e            last_src_q, last_src_d;
    logic            unexp_q, unexp_d;
    src_e            tag_q [MaxOutstanding];

    src_e winner;
    src_e head_tag;
    logic full;
    logic winner_req;
    logic mem_req;
    logic push;
    logic pop;

    // Fetches carry no store fields, so those inputs are intentionally ignored.
    logic unused_instr_fields;
    assign unused_instr_fields = ^{instr_if.we, instr_if.be, instr_if.wdata};

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    // Choose the requester: the locked one first, then the only one, then by priority or round-robin.
    always_comb begin
        // NOTE: give every always_comb target a default first so that no path infers a latch.
        winner = SrcInstr;
        if (lock_vld_q) begin
            winner = lock_src_q;
        end else if (instr_if.req && data_if.req) begin
            winner = DataPriority ? SrcData : src_e'(~last_src_q);
        end else if (data_if.req) begin
            winner = SrcData;
        end
    end

    assign full       = (cnt_q == CntMax);
    assign winner_req = (winner == SrcData) ? data_if.req : instr_if.req;
    assign mem_req    = !rst_i && !full && winner_req;
    assign push       = mem_req && mem_if.gnt;
    assign pop        = !rst_i && mem_if.rvalid && (cnt_q != '0);
    assign head_tag   = tag_q[rd_ptr_q];

    // Drive the shared port from the winner. A fetch has fixed store fields.
    always_comb begin
        mem_if.req   = mem_req;
        mem_if.we    = (winner == SrcData) ? data_if.we    : 1'b0;
        mem_if.be    = (winner == SrcData) ? data_if.be    : 4'hF;
        mem_if.addr  = (winner == SrcData) ? data_if.addr  : instr_if.addr;
        mem_if.wdata = (winner == SrcData) ? data_if.wdata : 32'h0;
    end

    // Grant goes to the winner only. Responses are steered by the head tag, and data/err are broadcast.
    always_comb begin
        instr_if.gnt    = push && (winner == SrcInstr);
        data_if.gnt     = push && (winner == SrcData);
        instr_if.rvalid = pop && (head_tag == SrcInstr);
        data_if.rvalid  = pop && (head_tag == SrcData);
        instr_if.rdata  = mem_if.rdata;
        data_if.rdata   = mem_if.rdata;
        instr_if.err    = mem_if.err;
        data_if.err     = mem_if.err;
    end

    assign unexp_rsp_o = unexp_q;

    // Next state for the count, the pointers, the lock, the round-robin history and the sticky error.
    always_comb begin
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        last_src_d = last_src_q;
        // A request that is presented but not granted is held. Dropping the request releases the lock.
        lock_vld_d = mem_req && !mem_if.gnt;
        lock_src_d = winner;
        unexp_d    = unexp_q | (mem_if.rvalid && (cnt_q == '0));
        if (push) begin
            wr_ptr_d   = ptr_inc(wr_ptr_q);
            last_src_d = winner;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state with a synchronous reset. Outstanding tags and the lock are dropped on reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so that all registers update together.
        if (rst_i) begin
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            lock_vld_q <= 1'b0;
            lock_src_q <= SrcInstr;
            last_src_q <= SrcData;
            unexp_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_src_q <= lock_src_d;
            last_src_q <= last_src_d;
            unexp_q    <= unexp_d;
        end
    end

    // Tag storage for outstanding transactions, written on each handshake.
    always_ff @(posedge clk_i) begin
        // NOTE: the tag array has no reset. An entry is read only while the count says it is valid.
        if (push) begin
            tag_q[wr_ptr_q] <= winner;
        end
    end
endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Directed bench for ibex_mem_arbiter. Both instances receive the same stimulus:
// dut0 is round-robin and dut1 has DataPriority set.
module tb_ibex_mem_arbiter;
    logic        clk;
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        mgnt;
    logic        mrvalid;
    logic [31:0] mrdata;
    logic        merr;
    logic        unexp0;
    logic        unexp1;

    int n_total = 0;
    int n_bad   = 0;

    ibex_mem_arbiter_if instr0();
    ibex_mem_arbiter_if data0();
    ibex_mem_arbiter_if mem0();
    ibex_mem_arbiter_if instr1();
    ibex_mem_arbiter_if data1();
    ibex_mem_arbiter_if mem1();

    assign instr0.req   = ireq;    assign instr1.req   = ireq;
    assign instr0.addr  = iaddr;   assign instr1.addr  = iaddr;
    assign instr0.we    = 1'b1;    assign instr1.we    = 1'b1;
    assign instr0.be    = 4'h1;    assign instr1.be    = 4'h1;
    assign instr0.wdata = 32'hFFFF_FFFF;
    assign instr1.wdata = 32'hFFFF_FFFF;
    assign data0.req    = dreq;    assign data1.req    = dreq;
    assign data0.we     = dwe;     assign data1.we     = dwe;
    assign data0.be     = dbe;     assign data1.be     = dbe;
    assign data0.addr   = daddr;   assign data1.addr   = daddr;
    assign data0.wdata  = dwdata;  assign data1.wdata  = dwdata;
    assign mem0.gnt     = mgnt;    assign mem1.gnt     = mgnt;
    assign mem0.rvalid  = mrvalid; assign mem1.rvalid  = mrvalid;
    assign mem0.rdata   = mrdata;  assign mem1.rdata   = mrdata;
    assign mem0.err     = merr;    assign mem1.err     = merr;

    ibex_mem_arbiter #(.MaxOutstanding(2), .DataPriority(1'b0)) u_dut0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .instr_if    (instr0),
        .data_if     (data0),
        .mem_if      (mem0),
        .unexp_rsp_o (unexp0)
    );

    ibex_mem_arbiter #(.MaxOutstanding(2), .DataPriority(1'b1)) u_dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .instr_if    (instr1),
        .data_if     (data1),
        .mem_if      (mem1),
        .unexp_rsp_o (unexp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_in();
        ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwe = 1'b0; dbe = '0; daddr = '0;
        dwdata = '0; mgnt = 1'b0; mrvalid = 1'b0; mrdata = '0; merr = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        do_reset();

        // Reset state
        settle();
        check("rst_mem_req", 32'(mem0.req), 0);
        check("rst_igrant", 32'(instr0.gnt), 0);
        check("rst_dgrant", 32'(data0.gnt), 0);
        check("rst_irvalid", 32'(instr0.rvalid), 0);
        check("rst_unexp", 32'(unexp0), 0);
        tick();

        // Instr-only fetch with grant tied high
        ireq = 1'b1; iaddr = 32'h80; mgnt = 1'b1;
        dwe = 1'b1; dbe = 4'h3; dwdata = 32'hDEAD_BEEF;
        settle();
        check("f_mem_req", 32'(mem0.req), 1);
        check("f_igrant", 32'(instr0.gnt), 1);
        check("f_dgrant", 32'(data0.gnt), 0);
        check("f_addr", mem0.addr, 32'h80);
        check("f_be", 32'(mem0.be), 32'hF);
        check("f_we", 32'(mem0.we), 0);
        check("f_wdata", mem0.wdata, 0);
        tick();
        ireq = 1'b0; mrvalid = 1'b1; mrdata = 32'h0000_0013;
        settle();
        check("f_irvalid", 32'(instr0.rvalid), 1);
        check("f_irdata", instr0.rdata, 32'h13);
        check("f_drvalid", 32'(data0.rvalid), 0);
        tick();

        // Both requesting every cycle: round-robin alternates (dut0), data always wins (dut1)
        do_reset();
        ireq = 1'b1; dreq = 1'b1; mgnt = 1'b1; iaddr = 32'h100; daddr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            mrvalid = (i > 0);
            mrdata  = 32'(i);
            settle();
            check($sformatf("rr_igrant%0d", i), 32'(instr0.gnt), 32'(i % 2 == 0));
            check($sformatf("rr_dgrant%0d", i), 32'(data0.gnt), 32'(i % 2 == 1));
            check($sformatf("rr_addr%0d", i), mem0.addr, (i % 2 == 1) ? 32'h200 : 32'h100);
            check($sformatf("pri_dgrant%0d", i), 32'(data1.gnt), 1);
            check($sformatf("pri_igrant%0d", i), 32'(instr1.gnt), 0);
            if (i > 0) begin
                check($sformatf("rr_irvalid%0d", i), 32'(instr0.rvalid), 32'(i % 2 == 1));
                check($sformatf("rr_drvalid%0d", i), 32'(data0.rvalid), 32'(i % 2 == 0));
                check($sformatf("pri_drvalid%0d", i), 32'(data1.rvalid), 1);
            end
            tick();
        end

        // Data request held for 3 cycles without grant while instr arrives; the lock keeps data
        do_reset();
        dreq = 1'b1; daddr = 32'h1000; dwe = 1'b1; dbe = 4'h3; dwdata = 32'h1234;
        iaddr = 32'h2000; mgnt = 1'b0;
        settle();
        check("lk_req_c1", 32'(mem0.req), 1);
        check("lk_addr_c1", mem0.addr, 32'h1000);
        check("lk_dgrant_c1", 32'(data0.gnt), 0);
        tick();
        ireq = 1'b1;
        settle();
        check("lk_addr_c2", mem0.addr, 32'h1000);
        check("lk_we_c2", 32'(mem0.we), 1);
        check("lk_igrant_c2", 32'(instr0.gnt), 0);
        tick();
        settle();
        check("lk_addr_c3", mem0.addr, 32'h1000);
        tick();
        mgnt = 1'b1;
        settle();
        check("lk_dgrant_c4", 32'(data0.gnt), 1);
        check("lk_igrant_c4", 32'(instr0.gnt), 0);
        check("lk_addr_c4", mem0.addr, 32'h1000);
        check("lk_wdata_c4", mem0.wdata, 32'h1234);
        tick();
        dreq = 1'b0;
        settle();
        check("lk_igrant_c5", 32'(instr0.gnt), 1);
        check("lk_addr_c5", mem0.addr, 32'h2000);
        check("lk_be_c5", 32'(mem0.be), 32'hF);
        tick();

        // Full: the third request waits for the first response, which routes to data
        do_reset();
        mgnt = 1'b1; dreq = 1'b1; daddr = 32'h3000;
        settle();
        check("fu_dgrant1", 32'(data0.gnt), 1);
        tick();
        dreq = 1'b0; ireq = 1'b1; iaddr = 32'h4000;
        settle();
        check("fu_igrant2", 32'(instr0.gnt), 1);
        tick();
        settle();
        check("fu_req3", 32'(mem0.req), 0);
        check("fu_igrant3", 32'(instr0.gnt), 0);
        tick();
        mrvalid = 1'b1; mrdata = 32'h55;
        settle();
        check("fu_drvalid4", 32'(data0.rvalid), 1);
        check("fu_irvalid4", 32'(instr0.rvalid), 0);
        check("fu_drdata4", data0.rdata, 32'h55);
        check("fu_req4", 32'(mem0.req), 0);
        tick();
        mrvalid = 1'b0;
        settle();
        check("fu_req5", 32'(mem0.req), 1);
        check("fu_igrant5", 32'(instr0.gnt), 1);
        tick();

        // Interleaved I, D, D, I with in-order responses A, B, C, D
        do_reset();
        mgnt = 1'b1; ireq = 1'b1;
        settle();
        check("il_igrant1", 32'(instr0.gnt), 1);
        tick();
        ireq = 1'b0; dreq = 1'b1; mrvalid = 1'b1; mrdata = 32'hA;
        settle();
        check("il_dgrant2", 32'(data0.gnt), 1);
        check("il_irvalid2", 32'(instr0.rvalid), 1);
        check("il_drvalid2", 32'(data0.rvalid), 0);
        check("il_irdata2", instr0.rdata, 32'hA);
        tick();
        mrdata = 32'hB; merr = 1'b1;
        settle();
        check("il_dgrant3", 32'(data0.gnt), 1);
        check("il_drvalid3", 32'(data0.rvalid), 1);
        check("il_irvalid3", 32'(instr0.rvalid), 0);
        check("il_drdata3", data0.rdata, 32'hB);
        check("il_derr3", 32'(data0.err), 1);
        tick();
        merr = 1'b0; dreq = 1'b0; ireq = 1'b1; mrdata = 32'hC;
        settle();
        check("il_igrant4", 32'(instr0.gnt), 1);
        check("il_drvalid4", 32'(data0.rvalid), 1);
        check("il_drdata4", data0.rdata, 32'hC);
        tick();
        ireq = 1'b0; mrdata = 32'hD;
        settle();
        check("il_irvalid5", 32'(instr0.rvalid), 1);
        check("il_drvalid5", 32'(data0.rvalid), 0);
        check("il_irdata5", instr0.rdata, 32'hD);
        tick();

        // Unexpected response with nothing outstanding
        mrdata = 32'hE;
        settle();
        check("ux_irvalid", 32'(instr0.rvalid), 0);
        check("ux_drvalid", 32'(data0.rvalid), 0);
        check("ux_before", 32'(unexp0), 0);
        tick();
        mrvalid = 1'b0;
        settle();
        check("ux_set", 32'(unexp0), 1);
        tick();
        tick();
        settle();
        check("ux_sticky", 32'(unexp0), 1);
        do_reset();
        settle();
        check("ux_reset", 32'(unexp0), 0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
